// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Multi-cycle MADD/MSUB and DIV sequencer for the execute stage.
//             Registers the MAC partial product, runs the divider handshake,
//             raises the pipeline stall and emits one HI/LO write per
//             completed instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cmd_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic [63:0] hilo_i,
  input  logic        annul_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        signed_div_o,
  output logic        div_annul_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MAC      = 2'd1;
  localparam logic [1:0] S_DIV_WAIT = 2'd2;

  localparam logic [2:0] CMD_MADD  = 3'd1;
  localparam logic [2:0] CMD_MADDU = 3'd2;
  localparam logic [2:0] CMD_MSUB  = 3'd3;
  localparam logic [2:0] CMD_MSUBU = 3'd4;
  localparam logic [2:0] CMD_DIV   = 3'd5;
  localparam logic [2:0] CMD_DIVU  = 3'd6;

  logic [1:0]  state_q, state_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sign_q, sign_d;

  // Command decode
  logic is_mac, is_div, is_sub, is_smac, div_by_zero;
  assign is_mac      = (cmd_i == CMD_MADD) || (cmd_i == CMD_MADDU) ||
                       (cmd_i == CMD_MSUB) || (cmd_i == CMD_MSUBU);
  assign is_div      = (cmd_i == CMD_DIV) || (cmd_i == CMD_DIVU);
  assign is_sub      = (cmd_i == CMD_MSUB) || (cmd_i == CMD_MSUBU);
  assign is_smac     = (cmd_i == CMD_MADD) || (cmd_i == CMD_MSUB);
  assign div_by_zero = (opb_i == 32'd0);

  // Partial product: signed or unsigned 32x32, negated for the MSUB family
  logic signed [63:0] smul;
  logic        [63:0] umul;
  logic        [63:0] mac_prod;
  logic        [63:0] prod_sel;
  logic        [63:0] mac_sum;
  assign smul     = $signed(opa_i) * $signed(opb_i);
  assign umul     = {32'd0, opa_i} * {32'd0, opb_i};
  assign mac_prod = is_smac ? smul : umul;
  assign prod_sel = is_sub ? (64'd0 - mac_prod) : mac_prod;
  // Accumulate uses the forwarded HI/LO of the write cycle, not the issue cycle
  assign mac_sum  = hilo_i + prod_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prod_q  <= 64'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sign_q  <= sign_d;
    end
  end

  // Next-state logic; annul overrides every transition and drops the product
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sign_d  = sign_q;
    case (state_q)
      S_IDLE: begin
        if (is_mac) begin
          prod_d  = prod_sel;
          state_d = S_MAC;
        end else if (is_div && !div_by_zero) begin
          opa_d   = opa_i;
          opb_d   = opb_i;
          sign_d  = (cmd_i == CMD_DIV);
          state_d = S_DIV_WAIT;
        end
      end
      S_MAC:      state_d = S_IDLE;
      S_DIV_WAIT: if (div_ready_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (annul_i) begin
      state_d = S_IDLE;
      prod_d  = 64'd0;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sign_d  = sign_q;
    end
  end

  // Output logic; reset and annul silence everything except the divider abort
  always_comb begin
    div_start_o   = 1'b0;
    div_opdata1_o = 32'd0;
    div_opdata2_o = 32'd0;
    signed_div_o  = 1'b0;
    div_annul_o   = 1'b0;
    stallreq_o    = 1'b0;
    whilo_o       = 1'b0;
    hi_o          = 32'd0;
    lo_o          = 32'd0;
    if (!rst) begin
      if (annul_i) begin
        div_annul_o = (state_q == S_DIV_WAIT);
      end else begin
        case (state_q)
          S_IDLE: begin
            if (is_mac) begin
              stallreq_o = 1'b1;
            end else if (is_div && div_by_zero) begin
              whilo_o = 1'b1;
              hi_o    = opa_i;
              lo_o    = 32'hFFFF_FFFF;
            end else if (is_div) begin
              // Divider starts in the issue cycle straight from the operand bus
              div_start_o   = 1'b1;
              div_opdata1_o = opa_i;
              div_opdata2_o = opb_i;
              signed_div_o  = (cmd_i == CMD_DIV);
              stallreq_o    = 1'b1;
            end
          end
          S_MAC: begin
            whilo_o = 1'b1;
            hi_o    = mac_sum[63:32];
            lo_o    = mac_sum[31:0];
          end
          S_DIV_WAIT: begin
            if (div_ready_i) begin
              whilo_o = 1'b1;
              hi_o    = div_result_i[63:32];
              lo_o    = div_result_i[31:0];
            end else begin
              div_start_o   = 1'b1;
              div_opdata1_o = opa_q;
              div_opdata2_o = opb_q;
              signed_div_o  = sign_q;
              stallreq_o    = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq
//  Purpose  : Self-checking bench for muldiv_seq. Expected HI/LO writes are
//             queued at issue and compared when whilo_o is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cmd_i;
  logic [31:0] opa_i, opb_i;
  logic [63:0] hilo_i;
  logic        annul_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic        signed_div_o, div_annul_o, stallreq_o, whilo_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_i        (cmd_i),
    .opa_i        (opa_i),
    .opb_i        (opb_i),
    .hilo_i       (hilo_i),
    .annul_i      (annul_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .div_start_o  (div_start_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .signed_div_o (signed_div_o),
    .div_annul_o  (div_annul_o),
    .stallreq_o   (stallreq_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {59'd0, div_start_o, div_annul_o, signed_div_o, stallreq_o, whilo_o}, 64'd0);
    check({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
    check({tag, "_ops"}, {div_opdata1_o, div_opdata2_o}, 64'd0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write must match the oldest queued expectation
  always @(negedge clk) begin
    if (whilo_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_whilo", {63'd0, whilo_o}, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("hilo_write", {hi_o, lo_o}, mon_exp);
        check("whilo_vs_stall", {63'd0, stallreq_o}, 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; cmd_i = 3'd1; opa_i = 32'd5; opb_i = 32'd6; hilo_i = 64'd1;
    annul_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'd0;

    // Reset with a command pending: everything quiet
    next(); next();
    @(negedge clk); check_idle("reset");
    next(); rst = 1'b0; cmd_i = 3'd0;
    @(negedge clk); check_idle("post_reset");

    // MADD signed: 0x10 + 3 * -2 = 0xA
    next(); cmd_i = 3'd1; hilo_i = 64'h10; opa_i = 32'd3; opb_i = 32'hFFFF_FFFE;
    exp_q.push_back(64'hA);
    @(negedge clk); check("madd_c0_stall", {63'd0, stallreq_o}, 64'd1);
    check("madd_c0_whilo", {63'd0, whilo_o}, 64'd0);
    next(); cmd_i = 3'd0;
    @(negedge clk); check("madd_c1_whilo", {63'd0, whilo_o}, 64'd1);
    check("madd_c1_stall", {63'd0, stallreq_o}, 64'd0);

    // MSUBU then back-to-back MADDU; MADDU shown during MAC must be ignored
    next(); cmd_i = 3'd4; hilo_i = 64'd0; opa_i = 32'hFFFF_FFFF; opb_i = 32'd2;
    exp_q.push_back(64'hFFFF_FFFE_0000_0002);
    @(negedge clk); check("msubu_c0_stall", {63'd0, stallreq_o}, 64'd1);
    next(); cmd_i = 3'd2; opa_i = 32'd1; opb_i = 32'd1;
    @(negedge clk); check("msubu_c1_whilo", {63'd0, whilo_o}, 64'd1);
    next(); exp_q.push_back(64'h1);
    @(negedge clk); check("maddu_c0_stall", {63'd0, stallreq_o}, 64'd1);
    next(); cmd_i = 3'd0;
    @(negedge clk); check("maddu_c1_whilo", {63'd0, whilo_o}, 64'd1);

    // MSUB signed: 100 - (-3 * 4) = 112
    next(); cmd_i = 3'd3; hilo_i = 64'd100; opa_i = 32'hFFFF_FFFD; opb_i = 32'd4;
    exp_q.push_back(64'd112);
    next(); cmd_i = 3'd0;
    @(negedge clk); check("msub_c1_whilo", {63'd0, whilo_o}, 64'd1);

    // DIV signed with a 34-cycle divider
    next(); cmd_i = 3'd5; opa_i = 32'hFFFF_FFF9; opb_i = 32'd2;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    for (int i = 0; i < 34; i++) begin
      if (i > 0) begin
        next(); cmd_i = 3'd0; opa_i = 32'hDEAD_BEEF; opb_i = 32'd0;
      end
      @(negedge clk);
      check("div_wait_ctl", {60'd0, div_start_o, signed_div_o, stallreq_o, whilo_o}, 64'hE);
      check("div_wait_ops", {div_opdata1_o, div_opdata2_o}, {32'hFFFF_FFF9, 32'd2});
    end
    next(); div_ready_i = 1'b1; div_result_i = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    @(negedge clk); check("div_ready_ctl", {61'd0, div_start_o, stallreq_o, whilo_o}, 64'h1);
    next(); div_ready_i = 1'b0;
    @(negedge clk); check_idle("div_done");

    // DIVU by zero completes immediately
    next(); cmd_i = 3'd6; opa_i = 32'h1234; opb_i = 32'd0;
    exp_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
    @(negedge clk); check("dbz_ctl", {61'd0, div_start_o, stallreq_o, whilo_o}, 64'h1);
    next(); cmd_i = 3'd0;
    @(negedge clk); check_idle("dbz_after");

    // Annul in the middle of a DIVU; later ready pulse must not write
    next(); cmd_i = 3'd6; opa_i = 32'd100; opb_i = 32'd7;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        next(); cmd_i = 3'd0;
      end
      @(negedge clk);
      check("divu_wait_ctl", {60'd0, div_start_o, signed_div_o, stallreq_o, whilo_o}, 64'hA);
    end
    next(); annul_i = 1'b1;
    @(negedge clk); check("annul_div_ctl", {61'd0, div_annul_o, stallreq_o, whilo_o}, 64'h4);
    next(); annul_i = 1'b0;
    @(negedge clk); check_idle("annul_div_after");
    next(); div_ready_i = 1'b1; div_result_i = {$urandom, $urandom};
    @(negedge clk); check("stray_ready_whilo", {63'd0, whilo_o}, 64'd0);
    next(); div_ready_i = 1'b0;

    // Annul together with an IDLE MADD: not started
    next(); cmd_i = 3'd1; opa_i = 32'd9; opb_i = 32'd9; annul_i = 1'b1;
    @(negedge clk); check("annul_idle_stall", {63'd0, stallreq_o}, 64'd0);
    next(); cmd_i = 3'd0; annul_i = 1'b0;
    @(negedge clk); check_idle("annul_idle_after");

    // Annul during MAC: write suppressed
    next(); cmd_i = 3'd1; hilo_i = 64'd5;
    next(); cmd_i = 3'd0; annul_i = 1'b1;
    @(negedge clk); check("annul_mac_ctl", {62'd0, stallreq_o, whilo_o}, 64'd0);
    next(); annul_i = 1'b0;
    @(negedge clk); check_idle("annul_mac_after");

    // Reset while in MAC, then a fresh MADD
    next(); cmd_i = 3'd1; hilo_i = 64'd0; opa_i = 32'd7; opb_i = 32'd9;
    @(negedge clk); check("rstmac_c0_stall", {63'd0, stallreq_o}, 64'd1);
    next(); rst = 1'b1; cmd_i = 3'd0;
    @(negedge clk); check_idle("rst_in_mac");
    next(); rst = 1'b0;
    @(negedge clk); check_idle("after_rst_mac");
    next(); cmd_i = 3'd1; opa_i = 32'd2; opb_i = 32'd2; hilo_i = 64'd0;
    exp_q.push_back(64'h4);
    @(negedge clk); check("madd2_c0_stall", {63'd0, stallreq_o}, 64'd1);
    next(); cmd_i = 3'd0;
    @(negedge clk); check("madd2_c1_whilo", {63'd0, whilo_o}, 64'd1);

    next();
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply-accumulate and divide sequencer for the execute stage. It replaces the ad-hoc cycle counter and temporary-product handshake inside EX with one FSM. The FSM registers the MADD/MSUB partial product, drives the iterative divider's start/operand/annul handshake, and raises the pipeline stall request. It emits exactly one HI/LO write per completed instruction. It sits between EX, the divider unit and ctrl (stall/flush).

## Interface
- No parameters; data width fixed at 32 (HI/LO pair 64).
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_i  in  3  0 NONE, 1 MADD, 2 MADDU, 3 MSUB, 4 MSUBU, 5 DIV, 6 DIVU, 7 treated as NONE
- opa_i  in  32  rs operand / dividend
- opb_i  in  32  rt operand / divisor
- hilo_i  in  64  forwarded current {HI,LO}
- annul_i  in  1  pipeline flush; kills the in-flight operation
- div_result_i  in  64  divider result {remainder, quotient}
- div_ready_i  in  1  divider result valid
- div_start_o  out  1  divider start, held high until ready
- div_opdata1_o  out  32  latched dividend
- div_opdata2_o  out  32  latched divisor
- signed_div_o  out  1  1 for DIV
- div_annul_o  out  1  divider abort
- stallreq_o  out  1  to ctrl; holds IF..EX
- whilo_o  out  1  HI/LO write enable (one cycle per instruction)
- hi_o, lo_o  out  32 each  HI/LO write data

## Operation
- States: IDLE, MAC, DIV_WAIT.
- IDLE, cmd MADD/MADDU/MSUB/MSUBU:
  - The 32x32 product is signed for MADD/MSUB and unsigned for MADDU/MSUBU.
  - For MSUB/MSUBU, the product is negated (two's complement, mod 2^64).
  - The result is registered into prod_q.
  - stallreq_o=1; go to MAC.
- MAC:
  - {hi_o,lo_o} = hilo_i + prod_q mod 2^64, with hilo_i sampled in this cycle.
  - whilo_o=1, stallreq_o=0; go to IDLE.
- IDLE, cmd DIV/DIVU, opb_i≠0:
  - Latch opa/opb/signedness into operand registers.
  - div_start_o=1 from the same cycle; div_opdata*_o are driven from opa/opb in IDLE and from the latches afterwards.
  - stallreq_o=1; go to DIV_WAIT.
- IDLE, cmd DIV/DIVU, opb_i=0 (divide by zero):
  - Complete in the same cycle with no divider start.
  - whilo_o=1, hi_o=opa_i, lo_o=32'hFFFF_FFFF, stallreq_o=0; stay in IDLE.
- DIV_WAIT:
  - div_start_o=1 and stallreq_o=1 while div_ready_i=0.
  - On div_ready_i=1: whilo_o=1, hi_o=div_result_i[63:32], lo_o=div_result_i[31:0], div_start_o=0, stallreq_o=0; go to IDLE.
- IDLE, cmd NONE: all outputs 0.
- cmd_i changes after leaving IDLE are ignored; the latched operation completes.
- div_opdata*_o and signed_div_o are 0 whenever div_start_o=0.
- annul_i:
  - Highest priority after rst, in any state.
  - Combinationally forces whilo_o=0 and stallreq_o=0, and asserts div_annul_o=1 if the state is DIV_WAIT.
  - Next state is IDLE and prod_q is cleared.
  - A command presented in IDLE together with annul_i is not started.
- rst: state IDLE, prod_q=0, operand latches 0.

## Timing
- Outputs during and after reset: every output is 0.
- MADD family:
  - Issue cycle: stall.
  - Issue+1: write and release; the instruction leaves EX on that edge.
  - Total 2 cycles; 1 stall cycle.
- DIV/DIVU:
  - Stall lasts from the issue cycle through the cycle before div_ready_i.
  - The write occurs in the div_ready_i cycle.
  - Latency = divider latency + 0 extra.
- Divide by zero: 1 cycle, no stall.
- Back-to-back commands are accepted the cycle after completion (IDLE), with no bubble.
- div_ready_i seen outside DIV_WAIT is ignored.
- whilo_o never asserts in the same cycle as stallreq_o=1.

## Test plan
- MADD: hilo_i=64'h10, opa=3, opb=32'hFFFF_FFFE.
  - Cycle 0: stallreq=1, whilo=0.
  - Cycle 1: whilo=1, {hi,lo}=64'hA, stallreq=0.
- MSUBU: hilo_i=0, opa=32'hFFFF_FFFF, opb=2.
  - Cycle 1: {hi,lo}=64'hFFFF_FFFE_0000_0002.
  - Then a second MADDU (opa=opb=1, hilo=0) issued immediately gives 64'h1 two cycles later.
- DIV: opa=32'hFFFF_FFF9, opb=2; divider model asserts ready 34 cycles after start with result {32'hFFFF_FFFF, 32'hFFFF_FFFD}.
  - div_start=1, signed_div=1 and stallreq=1 for 34 cycles.
  - Ready cycle: whilo=1, hi=FFFF_FFFF, lo=FFFF_FFFD.
- DIVU by zero: opa=32'h1234, opb=0.
  - Same cycle: whilo=1, hi=32'h1234, lo=FFFF_FFFF.
  - div_start never high; stallreq=0.
- Annul mid DIV: annul_i=1 on cycle 5 of DIV_WAIT.
  - That cycle: div_annul=1, stallreq=0, whilo=0.
  - Next cycle: IDLE with div_start=0; a later div_ready pulse produces no write.
- rst asserted in MAC:
  - Next cycle all outputs 0.
  - A following MADD with hilo=0, opa=opb=2 yields {hi,lo}=64'h4.
